// File: rtl/vga_frame_grabber.sv
// Snoops a VGA bus and captures one visible frame into a FWFT pixel FIFO on request.
// Optional GRABBER_CRC_EN adds FRAME_CRC, a CRC-16-CCITT over every captured pixel.
module vga_frame_grabber #(
  parameter int COLOR_DEPTH  = 4,
  parameter int X_WIDTH      = 640,
  parameter int Y_WIDTH      = 480,
  parameter int X_BACK_PORCH = 48,
  parameter int Y_BACK_PORCH = 33,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_POL     = 0
) (
  input  logic                     GCLK,
  input  logic                     BTNC,
  input  logic                     PIX_EN,
  input  logic [COLOR_DEPTH-1:0]   VGA_R,
  input  logic [COLOR_DEPTH-1:0]   VGA_G,
  input  logic [COLOR_DEPTH-1:0]   VGA_B,
  input  logic                     VGA_HS,
  input  logic                     VGA_VS,
  input  logic                     CAP_REQ,
  output logic [3*COLOR_DEPTH-1:0] PIX_DATA,
  output logic                     PIX_VLD,
  input  logic                     PIX_RDY,
  output logic                     PIX_SOF,
  output logic                     PIX_EOL,
  output logic                     BUSY,
  output logic                     FRAME_DONE,
`ifdef GRABBER_CRC_EN
  output logic                     OVERFLOW,
  output logic [15:0]              FRAME_CRC
`else
  output logic                     OVERFLOW
`endif
);
  localparam int DW  = 3 * COLOR_DEPTH;
  localparam int WW  = DW + 2;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int XW  = $clog2(X_WIDTH) + 1;
  localparam int YW  = $clog2(Y_WIDTH) + 1;
  localparam int LSW = $clog2(Y_BACK_PORCH) + 1;
  localparam int PSW = $clog2(X_BACK_PORCH) + 1;
  localparam logic            ACT      = (SYNC_POL != 0);
  localparam logic [XW-1:0]   COL_LAST = XW'(X_WIDTH - 1);
  localparam logic [YW-1:0]   ROW_LAST = YW'(Y_WIDTH - 1);
  localparam logic [LSW-1:0]  LS_INIT  = LSW'(Y_BACK_PORCH);
  localparam logic [PSW-1:0]  PS_INIT  = PSW'(X_BACK_PORCH);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_LINE, SKIP, ACTIVE} state_t;

  state_t         state_q;
  logic           hs_q, vs_q;
  logic [LSW-1:0] line_skip_q;
  logic [PSW-1:0] px_skip_q;
  logic [XW-1:0]  col_q;
  logic [YW-1:0]  row_q;
  logic           frame_done_q, overflow_q;
  logic [WW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;

  logic          hs_deassert, vs_deassert, wr_due, wr_en, rd_en, fifo_empty, fifo_full;
  logic [WW-1:0] wr_word, rd_word;

  // Edges compare the registered sync against the current sample, only on pixel enables.
  assign hs_deassert = PIX_EN && (hs_q == ACT) && (VGA_HS != ACT);
  assign vs_deassert = PIX_EN && (vs_q == ACT) && (VGA_VS != ACT);
  assign wr_due      = (state_q == ACTIVE) && PIX_EN && !vs_deassert;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign rd_en       = !fifo_empty && PIX_RDY;
  assign wr_en       = wr_due && (!fifo_full || rd_en);
  assign wr_word     = {(row_q == '0) && (col_q == '0), col_q == COL_LAST, VGA_R, VGA_G, VGA_B};
  assign rd_word     = mem_q[rd_ptr_q];

  assign PIX_VLD    = !fifo_empty;
  assign PIX_DATA   = fifo_empty ? '0 : rd_word[DW-1:0];
  assign PIX_EOL    = !fifo_empty && rd_word[DW];
  assign PIX_SOF    = !fifo_empty && rd_word[DW+1];
  assign BUSY       = (state_q != IDLE);
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;

  always_ff @(posedge GCLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge GCLK) begin
    if (BTNC) begin
      state_q      <= IDLE;
      hs_q         <= ~ACT;
      vs_q         <= ~ACT;
      line_skip_q  <= '0;
      px_skip_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (PIX_EN) begin
        hs_q <= VGA_HS;
        vs_q <= VGA_VS;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (wr_due && !wr_en) overflow_q <= 1'b1;

      case (state_q)
        IDLE: if (CAP_REQ) begin
          overflow_q <= 1'b0;
          state_q    <= WAIT_VS;
        end
        WAIT_VS: if (vs_deassert) begin
          line_skip_q <= LS_INIT;
          row_q       <= '0;
          state_q     <= WAIT_LINE;
        end
        WAIT_LINE: begin
          if (vs_deassert) begin
            overflow_q <= 1'b1;
            state_q    <= IDLE;
          end else if (hs_deassert) begin
            if (line_skip_q != '0) begin
              line_skip_q <= line_skip_q - LSW'(1);
            end else begin
              col_q     <= '0;
              px_skip_q <= PS_INIT;
              state_q   <= (X_BACK_PORCH == 0) ? ACTIVE : SKIP;
            end
          end
        end
        SKIP: begin
          if (vs_deassert) begin
            overflow_q <= 1'b1;
            state_q    <= IDLE;
          end else if (PIX_EN) begin
            px_skip_q <= px_skip_q - PSW'(1);
            if (px_skip_q == PSW'(1)) state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_deassert) begin
            overflow_q <= 1'b1;
            state_q    <= IDLE;
          end else if (PIX_EN) begin
            col_q <= col_q + XW'(1);
            if (col_q == COL_LAST) begin
              if (row_q == ROW_LAST) begin
                frame_done_q <= 1'b1;
                state_q      <= IDLE;
              end else begin
                row_q       <= row_q + YW'(1);
                line_skip_q <= '0;
                state_q     <= WAIT_LINE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef GRABBER_CRC_EN
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [DW-1:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  logic [15:0] crc_q;
  assign FRAME_CRC = crc_q;

  // Dropped pixels still fold into the CRC so it reflects the renderer, not the FIFO.
  always_ff @(posedge GCLK) begin
    if (BTNC)                              crc_q <= 16'h0000;
    else if ((state_q == IDLE) && CAP_REQ) crc_q <= 16'hFFFF;
    else if (wr_due)                       crc_q <= crc_next(crc_q, {VGA_R, VGA_G, VGA_B});
  end
`endif
endmodule
